// File: rtl/multi_source_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : multi_source_frame_tx
// Description : Gathers per-source update slots and sends them as one framed,
//               MSB-first serial word (seq | fresh mask | slots) over a
//               data / clock / active-low select link.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_source_frame_tx #(
    parameter int NUM_SRC      = 2,
    parameter int SRC_WIDTH    = 32,
    parameter int SEQ_WIDTH    = 4,
    parameter int DATA_PERIOD  = 100,
    parameter int TRIGGER_MODE = 0
) (
    input  logic                          clk_pixel_in,
    input  logic                          rst_in,
    input  logic [NUM_SRC*SRC_WIDTH-1:0]  src_data_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    input  logic                          force_in,
    output logic                          data_out,
    output logic                          data_clk_out,
    output logic                          sel_out,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic [SEQ_WIDTH-1:0]          seq_out,
    output logic [NUM_SRC-1:0]            overrun_out
);

    localparam int FRAME_W = SEQ_WIDTH + NUM_SRC + NUM_SRC * SRC_WIDTH;
    localparam int PW      = $clog2(DATA_PERIOD);
    localparam int BW      = $clog2(FRAME_W);

    localparam logic [PW-1:0] c_last_phase = PW'(DATA_PERIOD - 1);
    localparam logic [PW-1:0] c_half_phase = PW'(DATA_PERIOD / 2);
    localparam logic [BW-1:0] c_last_bit   = BW'(FRAME_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]                   r_state;
    logic [NUM_SRC*SRC_WIDTH-1:0] r_slots;
    logic [NUM_SRC-1:0]           r_fresh;
    logic [NUM_SRC-1:0]           r_overrun;
    logic [FRAME_W-1:0]           r_shift;
    logic [PW-1:0]                r_phase;
    logic [BW-1:0]                r_bit;
    logic [SEQ_WIDTH-1:0]         r_seq;
    logic                         r_dclk;
    logic                         r_sel;
    logic                         r_busy;
    logic                         r_done;

    logic                         w_fresh_trig;
    logic                         w_snapshot;
    logic [FRAME_W-1:0]           w_frame;
    logic [PW-1:0]                w_phase_inc;

    generate
        if (TRIGGER_MODE == 0) begin : g_trig_all
            assign w_fresh_trig = &r_fresh;
        end else begin : g_trig_any
            assign w_fresh_trig = |r_fresh;
        end
    endgenerate

    assign w_snapshot  = (r_state == S_IDLE) && (w_fresh_trig || force_in);
    assign w_frame     = {r_seq, r_fresh, r_slots};
    assign w_phase_inc = r_phase + 1'b1;

    // A valid landing in the snapshot cycle re-arms fresh and is not an overwrite.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_slots   <= '0;
            r_fresh   <= '0;
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid_in[i]) begin
                    r_slots[i*SRC_WIDTH +: SRC_WIDTH] <= src_data_in[i*SRC_WIDTH +: SRC_WIDTH];
                end
            end
            r_fresh   <= (w_snapshot ? '0 : r_fresh) | src_valid_in;
            r_overrun <= r_overrun | (r_fresh & src_valid_in & {NUM_SRC{~w_snapshot}});
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_phase <= '0;
            r_bit   <= '0;
            r_seq   <= '0;
            r_dclk  <= 1'b0;
            r_sel   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_snapshot) begin
                        r_state <= S_SHIFT;
                        r_shift <= w_frame;
                        r_phase <= '0;
                        r_bit   <= '0;
                        r_dclk  <= 1'b0;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_phase == c_last_phase) begin
                        r_phase <= '0;
                        r_dclk  <= 1'b0;
                        if (r_bit == c_last_bit) begin
                            r_state <= S_GAP;
                            r_shift <= '0;
                            r_sel   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_seq   <= r_seq + 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        r_phase <= w_phase_inc;
                        r_dclk  <= (w_phase_inc >= c_half_phase);
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out       = r_shift[FRAME_W-1];
    assign data_clk_out   = r_dclk;
    assign sel_out        = r_sel;
    assign busy_out       = r_busy;
    assign frame_done_out = r_done;
    assign seq_out        = r_seq;
    assign overrun_out    = r_overrun;

endmodule
`default_nettype wire

// File: doc/multi_source_frame_tx.md
Name: multi_source_frame_tx

Overview:
- Collects independent update streams from NUM_SRC producers, such as FSM state, player location and score, into per-source slot registers.
- When its trigger policy is met, it snapshots all slots into one frame, prefixed with a sequence number and a freshness mask.
- Serialises the frame MSB-first over the board-to-board SPI-style link (data / clock / select).
- Generalises the two-source gather-then-send transmitter: parametrised source count and width, selectable trigger mode, force trigger, overrun detection and frame sequencing.

Parameters:
- NUM_SRC, 2: number of producer channels (1..8).
- SRC_WIDTH, 32: bits per source slot.
- SEQ_WIDTH, 4: width of the frame sequence counter.
- DATA_PERIOD, 100: clk_pixel_in cycles per serial bit; even, >= 2.
- TRIGGER_MODE, 0: 0 = send when all sources fresh; 1 = send when any source fresh.

Ports:
- clk_pixel_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- src_data_in, input, NUM_SRC*SRC_WIDTH: source i occupies bits [i*SRC_WIDTH +: SRC_WIDTH].
- src_valid_in, input, NUM_SRC: one-cycle update strobe per source.
- force_in, input, 1: request a frame now, regardless of freshness.
- data_out, output, 1: serial data.
- data_clk_out, output, 1: serial clock.
- sel_out, output, 1: frame select, active low.
- busy_out, output, 1: high while a frame is in flight.
- frame_done_out, output, 1: one-cycle pulse after the last bit.
- seq_out, output, SEQ_WIDTH: sequence number of the next frame.
- overrun_out, output, NUM_SRC: sticky per-source overwrite flag.

Behaviour:
- The single clock is clk_pixel_in. Reset rst_in is synchronous and active-high.
- Reset values:
  - sel_out=1, data_clk_out=0, data_out=0, busy_out=0, frame_done_out=0.
  - seq_out=0, overrun_out=0, all slots=0, all fresh bits=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately: sel_out returns high the next cycle and no frame_done_out pulse is issued.
- Slot capture:
  - src_valid_in[i] writes slot[i] and sets fresh[i], in every state.
  - If fresh[i] is already 1 when valid arrives, overrun_out[i] sets; it clears only on reset.
- Frame layout, FRAME_W = SEQ_WIDTH + NUM_SRC + NUM_SRC*SRC_WIDTH bits, MSB first:
  - seq_out, then the fresh mask (bit NUM_SRC-1 first), then slot[NUM_SRC-1] down to slot[0].
- FSM: IDLE -> SHIFT -> GAP -> IDLE.
  - IDLE: a trigger is any of:
    - TRIGGER_MODE 0 and all fresh bits set;
    - TRIGGER_MODE 1 and any fresh bit set;
    - force_in.
  - Trigger in IDLE at cycle T:
    - At T the frame is snapshotted into the shift register and all fresh bits clear.
    - At T+1: sel_out=0, busy_out=1, data_out=frame MSB, data_clk_out=0.
  - SHIFT: each bit lasts DATA_PERIOD cycles.
    - data_clk_out is low for the first DATA_PERIOD/2 cycles and high for the second half.
    - data_out changes only at bit boundaries, i.e. on the clock's falling edge.
  - After FRAME_W*DATA_PERIOD cycles in SHIFT, the FSM enters GAP for exactly one cycle:
    - sel_out=1, data_clk_out=0, busy_out=0, frame_done_out=1.
    - seq_out increments (wraps 2^SEQ_WIDTH-1 -> 0).
  - GAP ignores triggers; the next frame can start at the earliest from the IDLE cycle after GAP.
- Simultaneous events:
  - src_valid_in[i] in the snapshot cycle T: the snapshot uses the old slot value, the slot takes the new value, and fresh[i] ends up 1. Setting has priority over the snapshot clear, and no overrun is flagged.
  - Valid during SHIFT updates the slot only; the in-flight frame is unaffected.
  - force_in while busy is ignored (not queued).
  - force_in with no fresh sources sends the stale slots with mask 0.

Test Plan:
Config for all cases: NUM_SRC=2, SRC_WIDTH=8, SEQ_WIDTH=4, DATA_PERIOD=4, giving FRAME_W=22 and 88 shift cycles.
- Reset then idle 50 cycles -> sel_out=1, data_clk_out=0, busy_out=0, no frame.
- Mode 0: valid src0=0xA5 at cycle 10, src1=0x3C at cycle 20:
  - sel_out falls at cycle 22; bits sampled on data_clk_out rising edges = 0000_11_00111100_10100101.
  - frame_done_out pulses at cycle 110; seq_out=1.
- Mode 0, only src0 valid -> no frame. Then force_in -> frame with mask 01 and slot1=0x00.
- Mode 1: src1=0x81 valid -> frame with mask 10. A second src1 valid during SHIFT does not corrupt the frame and triggers the next frame after GAP.
- Two src0 valids without an intervening frame (mode 0, src1 idle) -> overrun_out=01, held until rst_in. Valid coincident with the snapshot cycle -> no overrun, fresh[0]=1 afterwards.
- 16 forced frames -> seq_out wraps 15 -> 0. Reset asserted at bit 5 of a frame -> sel_out=1 next cycle, seq_out=0, no frame_done_out.
